// File: rtl/pkt_sort_pkg.sv
// Shared definitions for the parametrised packet sorter.
// Optional build macro used by the top level: PKT_SORTER_INDEX_EN.
package pkt_sort_pkg;

   // Controller phases: capture, compare-swap passes, stream out
   typedef enum logic [1:0] {
      ST_RECV = 2'd0,
      ST_SORT = 2'd1,
      ST_SEND = 2'd2
   } state_e;

   // Number of packet slots addressable with adr_width bits
   function automatic int unsigned depth_of(input int unsigned adr_width);
      return 32'd1 << adr_width;
   endfunction

endpackage

// File: rtl/pkt_sort_cmp.sv
// Compare stage of the sort engine: asks for a swap when the lower-indexed
// word a_i is out of order with respect to b_i. Equal words never swap.
module pkt_sort_cmp #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter bit          SIGNED_CMP = 1'b0
) (
   input  logic [DATA_WIDTH-1:0] a_i,
   input  logic [DATA_WIDTH-1:0] b_i,
   input  logic                  desc_i,
   output logic                  swap_req_o
);

   logic a_gt_b;
   logic a_lt_b;

   // Strict ordering of a_i against b_i in the configured number format
   always_comb begin
      if (SIGNED_CMP) begin
         a_gt_b = $signed(a_i) > $signed(b_i);
         a_lt_b = $signed(a_i) < $signed(b_i);
      end else begin
         a_gt_b = a_i > b_i;
         a_lt_b = a_i < b_i;
      end
      swap_req_o = desc_i ? a_lt_b : a_gt_b;
   end

endmodule

// File: rtl/pkt_sorter_param.sv
// Packet sorter: captures one sop/eop framed packet, bubble-sorts it one
// compare-swap per cycle, then streams it out under ready_i backpressure.
// Build macro PKT_SORTER_INDEX_EN adds idx_o (arrival index of each word).
module pkt_sorter_param
   import pkt_sort_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned ADR_WIDTH  = 3,
   parameter bit          SIGNED_CMP = 1'b0
) (
   input  logic                  clk_i,
   input  logic                  async_rst_n_i,
   input  logic                  sop_i,
   input  logic                  eop_i,
   input  logic                  val_i,
   input  logic [DATA_WIDTH-1:0] data_i,
   input  logic                  desc_i,
   input  logic                  ready_i,
   output logic                  sop_o,
   output logic                  eop_o,
   output logic                  val_o,
   output logic [DATA_WIDTH-1:0] data_o,
   output logic                  err_o,
`ifdef PKT_SORTER_INDEX_EN
   output logic [ADR_WIDTH-1:0]  idx_o,
`endif
   output logic                  busy_o
);

   localparam int unsigned   DEPTH   = depth_of(ADR_WIDTH);
   localparam int unsigned   LW      = ADR_WIDTH + 1;
   localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
   localparam logic [LW-1:0] ONE_L   = LW'(1);
   localparam logic [LW-1:0] TWO_L   = LW'(2);

   state_e                  state_q;
   logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
   logic [DATA_WIDTH-1:0]   mem_d [DEPTH];
   logic [LW-1:0]           cnt_q;
   logic                    started_q;
   logic                    ovf_q;
   logic                    desc_q;
   logic                    swapped_q;
   logic [ADR_WIDTH-1:0]    i_q;
   logic [ADR_WIDTH-1:0]    rd_q;
   logic                    busy_q;
   logic                    val_q;
   logic                    sop_q;
   logic                    eop_q;
   logic                    err_q;
   logic [DATA_WIDTH-1:0]   data_q;

   logic                    accept;
   logic                    cap_sop;
   logic                    cap_cont;
   logic                    cap_room;
   logic                    cap_we;
   logic [ADR_WIDTH-1:0]    cap_adr;
   logic [LW-1:0]           cnt_nxt;
   logic                    ovf_nxt;
   logic                    closing;
   logic [ADR_WIDTH-1:0]    i_nxt;
   logic [ADR_WIDTH-1:0]    rd_nxt;
   logic [DATA_WIDTH-1:0]   word_a;
   logic [DATA_WIDTH-1:0]   word_b;
   logic                    swap_req;
   logic                    in_sort;
   logic                    do_swap;
   logic                    pass_end;
   logic                    last_nxt;
   logic                    xfer;
   logic                    load_single;
   logic                    sort_done;
   logic                    adv;
   logic                    drain;

   // Capture, sort-step and output-step decode
   always_comb begin
      accept   = val_i && !busy_q;
      cap_sop  = accept && sop_i;
      cap_cont = accept && !sop_i && started_q;
      cap_room = cnt_q < DEPTH_L;
      cap_we   = cap_sop || (cap_cont && cap_room);
      cap_adr  = cap_sop ? '0 : cnt_q[ADR_WIDTH-1:0];
      cnt_nxt  = cap_sop ? ONE_L : (cap_room ? cnt_q + ONE_L : cnt_q);
      ovf_nxt  = cap_sop ? 1'b0 : (ovf_q || (cap_cont && !cap_room));
      closing  = (cap_sop || cap_cont) && eop_i;

      i_nxt    = i_q + ADR_WIDTH'(1);
      rd_nxt   = rd_q + ADR_WIDTH'(1);
      word_a   = mem_q[i_q];
      word_b   = mem_q[i_nxt];
      in_sort  = state_q == ST_SORT;
      do_swap  = in_sort && swap_req;
      pass_end = {1'b0, i_q} == (cnt_q - TWO_L);
      last_nxt = {1'b0, rd_nxt} == (cnt_q - ONE_L);
      xfer     = val_q && ready_i;

      load_single = (state_q == ST_RECV) && closing && (cnt_nxt == ONE_L);
      // A pass with no swap leaves the array untouched, so mem_q[0] is final
      sort_done   = in_sort && pass_end && !(swapped_q || swap_req);
      adv         = (state_q == ST_SEND) && xfer && !eop_q;
      drain       = (state_q == ST_SEND) && xfer && eop_q;
   end

   pkt_sort_cmp #(
      .DATA_WIDTH (DATA_WIDTH),
      .SIGNED_CMP (SIGNED_CMP)
   ) u_cmp (
      .a_i        (word_a),
      .b_i        (word_b),
      .desc_i     (desc_q),
      .swap_req_o (swap_req)
   );

   // Next array contents: capture write or adjacent swap (never both)
   always_comb begin
      mem_d = mem_q;
      if (cap_we) begin
         mem_d[cap_adr] = data_i;
      end
      if (do_swap) begin
         mem_d[i_q]   = word_b;
         mem_d[i_nxt] = word_a;
      end
   end

   // Packet storage, contents irrelevant after reset
   always_ff @(posedge clk_i) begin
      mem_q <= mem_d;
   end

   // Control FSM with registered stream outputs
   always_ff @(posedge clk_i or negedge async_rst_n_i) begin
      if (!async_rst_n_i) begin
         state_q   <= ST_RECV;
         cnt_q     <= '0;
         started_q <= 1'b0;
         ovf_q     <= 1'b0;
         desc_q    <= 1'b0;
         swapped_q <= 1'b0;
         i_q       <= '0;
         rd_q      <= '0;
         busy_q    <= 1'b0;
         val_q     <= 1'b0;
         sop_q     <= 1'b0;
         eop_q     <= 1'b0;
         err_q     <= 1'b0;
         data_q    <= '0;
      end else begin
         case (state_q)
            ST_RECV: begin
               if (cap_sop) begin
                  desc_q <= desc_i;
               end
               if (cap_sop || cap_cont) begin
                  cnt_q     <= cnt_nxt;
                  ovf_q     <= ovf_nxt;
                  started_q <= 1'b1;
               end
               if (closing) begin
                  started_q <= 1'b0;
                  busy_q    <= 1'b1;
                  i_q       <= '0;
                  swapped_q <= 1'b0;
                  rd_q      <= '0;
                  if (load_single) begin
                     state_q <= ST_SEND;
                     val_q   <= 1'b1;
                     sop_q   <= 1'b1;
                     eop_q   <= 1'b1;
                     err_q   <= ovf_nxt;
                     data_q  <= data_i;
                  end else begin
                     state_q <= ST_SORT;
                  end
               end
            end
            ST_SORT: begin
               if (pass_end) begin
                  if (sort_done) begin
                     state_q <= ST_SEND;
                     val_q   <= 1'b1;
                     sop_q   <= 1'b1;
                     eop_q   <= 1'b0;
                     err_q   <= 1'b0;
                     data_q  <= mem_q[0];
                  end else begin
                     i_q       <= '0;
                     swapped_q <= 1'b0;
                  end
               end else begin
                  i_q       <= i_nxt;
                  swapped_q <= swapped_q || swap_req;
               end
            end
            ST_SEND: begin
               if (drain) begin
                  state_q <= ST_RECV;
                  busy_q  <= 1'b0;
                  val_q   <= 1'b0;
                  sop_q   <= 1'b0;
                  eop_q   <= 1'b0;
                  err_q   <= 1'b0;
                  data_q  <= '0;
                  ovf_q   <= 1'b0;
                  cnt_q   <= '0;
               end else if (adv) begin
                  rd_q   <= rd_nxt;
                  data_q <= mem_q[rd_nxt];
                  sop_q  <= 1'b0;
                  eop_q  <= last_nxt;
                  err_q  <= last_nxt && ovf_q;
               end
            end
            default: state_q <= ST_RECV;
         endcase
      end
   end

`ifdef PKT_SORTER_INDEX_EN
   logic [ADR_WIDTH-1:0] idx_mem_q [DEPTH];
   logic [ADR_WIDTH-1:0] idx_mem_d [DEPTH];
   logic [ADR_WIDTH-1:0] idx_q;

   // Arrival indices travel with their words through every swap
   always_comb begin
      idx_mem_d = idx_mem_q;
      if (cap_we) begin
         idx_mem_d[cap_adr] = cap_adr;
      end
      if (do_swap) begin
         idx_mem_d[i_q]   = idx_mem_q[i_nxt];
         idx_mem_d[i_nxt] = idx_mem_q[i_q];
      end
   end

   // Index storage, contents irrelevant after reset
   always_ff @(posedge clk_i) begin
      idx_mem_q <= idx_mem_d;
   end

   // Registered index output, loaded alongside data_o
   always_ff @(posedge clk_i or negedge async_rst_n_i) begin
      if (!async_rst_n_i) begin
         idx_q <= '0;
      end else if (load_single || drain) begin
         idx_q <= '0;
      end else if (sort_done) begin
         idx_q <= idx_mem_q[0];
      end else if (adv) begin
         idx_q <= idx_mem_q[rd_nxt];
      end
   end

   assign idx_o = idx_q;
`endif

   assign sop_o  = sop_q;
   assign eop_o  = eop_q;
   assign val_o  = val_q;
   assign data_o = data_q;
   assign err_o  = err_q;
   assign busy_o = busy_q;

endmodule

// File: tb/tb_pkt_sorter_param.sv
// Self-checking bench for pkt_sorter_param: an unsigned and a signed
// instance share all inputs; each is checked against a stable-sort model.
module tb_pkt_sorter_param;

   localparam int unsigned DW    = 8;
   localparam int unsigned AW    = 3;
   localparam int unsigned DEPTH = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          sop_i, eop_i, val_i, desc_i, ready_i;
   logic [DW-1:0] data_i;
   logic          o_sop [2];
   logic          o_eop [2];
   logic          o_val [2];
   logic          o_err [2];
   logic          o_busy [2];
   logic [DW-1:0] o_data [2];
`ifdef PKT_SORTER_INDEX_EN
   logic [AW-1:0] o_idx [2];
`endif

   int checks = 0;
   int errors = 0;

   logic [DW-1:0] pkt_w [16];
   int            pkt_n;
   int            exp_len;
   bit            exp_err;
   logic [DW-1:0] exp_d [2][DEPTH];
   int            exp_i [2][DEPTH];

   always #5 clk = ~clk;

   pkt_sorter_param #(.DATA_WIDTH(DW), .ADR_WIDTH(AW), .SIGNED_CMP(1'b0)) u_uns (
      .clk_i(clk), .async_rst_n_i(rst_n), .sop_i(sop_i), .eop_i(eop_i), .val_i(val_i),
      .data_i(data_i), .desc_i(desc_i), .ready_i(ready_i), .sop_o(o_sop[0]), .eop_o(o_eop[0]),
      .val_o(o_val[0]), .data_o(o_data[0]), .err_o(o_err[0]),
`ifdef PKT_SORTER_INDEX_EN
      .idx_o(o_idx[0]),
`endif
      .busy_o(o_busy[0]));

   pkt_sorter_param #(.DATA_WIDTH(DW), .ADR_WIDTH(AW), .SIGNED_CMP(1'b1)) u_sgn (
      .clk_i(clk), .async_rst_n_i(rst_n), .sop_i(sop_i), .eop_i(eop_i), .val_i(val_i),
      .data_i(data_i), .desc_i(desc_i), .ready_i(ready_i), .sop_o(o_sop[1]), .eop_o(o_eop[1]),
      .val_o(o_val[1]), .data_o(o_data[1]), .err_o(o_err[1]),
`ifdef PKT_SORTER_INDEX_EN
      .idx_o(o_idx[1]),
`endif
      .busy_o(o_busy[1]));

   task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s dut%0d: observed %0h expected %0h", tag, d, obs, exp);
      end
   endtask

   // Ordinal key: signed words map to offset-binary so plain compare orders them
   function automatic logic [DW-1:0] key(input logic [DW-1:0] w, input bit sgn);
      return sgn ? (w ^ {1'b1, {(DW-1){1'b0}}}) : w;
   endfunction

   // Stable sort by insertion: each new word goes after every word that may precede it
   task automatic build_model(input bit desc);
      exp_len = (pkt_n > DEPTH) ? DEPTH : pkt_n;
      exp_err = pkt_n > DEPTH;
      for (int d = 0; d < 2; d++) begin
         logic [DW-1:0] qd[$];
         int            qi[$];
         int            pos;
         for (int k = 0; k < exp_len; k++) begin
            pos = 0;
            for (int e = 0; e < qd.size(); e++) begin
               if (desc ? (key(qd[e], d == 1) >= key(pkt_w[k], d == 1))
                        : (key(qd[e], d == 1) <= key(pkt_w[k], d == 1)))
                  pos++;
            end
            qd.insert(pos, pkt_w[k]);
            qi.insert(pos, k);
         end
         for (int k = 0; k < exp_len; k++) begin
            exp_d[d][k] = qd[k];
            exp_i[d][k] = qi[k];
         end
      end
   endtask

   task automatic load(input int n, input logic [127:0] v);
      pkt_n = n;
      for (int k = 0; k < n; k++) pkt_w[k] = v[8*(n-1-k) +: 8];
   endtask

   // Junk beat before sop, optional aborted prefix, then the packet itself
   task automatic send_pkt(input bit desc, input int restart_len);
      @(posedge clk); #1;
      val_i = 1'b1; sop_i = 1'b0; eop_i = 1'($urandom % 2); data_i = DW'($urandom); desc_i = 1'($urandom);
      @(posedge clk); #1;
      for (int k = 0; k < restart_len; k++) begin
         val_i = 1'b1; sop_i = (k == 0); eop_i = 1'b0; data_i = DW'($urandom); desc_i = ~desc;
         @(posedge clk); #1;
      end
      for (int k = 0; k < pkt_n; k++) begin
         val_i  = 1'b1;
         sop_i  = (k == 0);
         eop_i  = (k == pkt_n - 1);
         data_i = pkt_w[k];
         desc_i = (k == 0) ? desc : 1'($urandom);
         @(posedge clk); #1;
      end
   endtask

   // rmode: 0 ready always, 1 ready toggles 1010.., 2 random; exp_sort < 0 skips the cycle check
   task automatic run_pkt(input bit desc, input int rmode, input int exp_sort, input int restart_len);
      int          got [2];
      bit          done [2];
      bit          post [2];
      bit          stall [2];
      logic [11:0] held [2];
      int          lat [2];
      int          g;
      build_model(desc);
      send_pkt(desc, restart_len);
      for (int d = 0; d < 2; d++) begin
         got[d] = 0; done[d] = 0; post[d] = 0; stall[d] = 0; held[d] = '0; lat[d] = -1;
      end
      for (int cyc = 0; cyc < 400 && !(post[0] && post[1]); cyc++) begin
         val_i = 1'($urandom % 2); sop_i = 1'b0; eop_i = 1'($urandom % 2); data_i = DW'($urandom);
         ready_i = (rmode == 0) ? 1'b1 : (rmode == 1) ? (cyc % 2 == 0) : ($urandom % 4 != 0);
         @(negedge clk);
         for (int d = 0; d < 2; d++) begin
            if (post[d]) continue;
            if (cyc == 0) chk("busy_after_eop", d, o_busy[d], 1);
            if (done[d]) begin
               chk("val_after_last", d, o_val[d], 0);
               chk("busy_after_last", d, o_busy[d], 0);
               post[d] = 1;
               continue;
            end
            if (stall[d]) chk("stall_hold", d, {o_val[d], o_sop[d], o_eop[d], o_err[d], o_data[d]}, held[d]);
            if (o_val[d] && lat[d] < 0) begin
               lat[d] = cyc;
               if (exp_sort >= 0) chk("sort_cycles", d, cyc, exp_sort);
            end
            if (o_val[d] && ready_i) begin
               g = got[d];
               if (g >= exp_len) begin
                  chk("extra_beat", d, g, exp_len - 1);
                  done[d] = 1;
               end else begin
                  chk("data", d, o_data[d], exp_d[d][g]);
                  chk("sop", d, o_sop[d], (g == 0));
                  chk("eop", d, o_eop[d], (g == exp_len - 1));
                  chk("err", d, o_err[d], (g == exp_len - 1) && exp_err);
`ifdef PKT_SORTER_INDEX_EN
                  chk("idx", d, o_idx[d], exp_i[d][g]);
`endif
                  got[d]++;
                  if (o_eop[d]) begin
                     chk("beat_count", d, got[d], exp_len);
                     done[d] = 1;
                  end
               end
            end
            stall[d] = o_val[d] && !ready_i;
            held[d]  = {o_val[d], o_sop[d], o_eop[d], o_err[d], o_data[d]};
         end
         @(posedge clk); #1;
      end
      for (int d = 0; d < 2; d++) chk("completed", d, post[d], 1);
      val_i = 1'b0; sop_i = 1'b0; eop_i = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; sop_i = 1'b0; eop_i = 1'b0; val_i = 1'b0; desc_i = 1'b0; ready_i = 1'b1; data_i = '0;
      repeat (2) @(posedge clk); #1;
      for (int d = 0; d < 2; d++) begin
         chk("rst_val", d, o_val[d], 0);
         chk("rst_busy", d, o_busy[d], 0);
         chk("rst_outs", d, {o_sop[d], o_eop[d], o_err[d], o_data[d]}, 0);
      end
      rst_n = 1'b1;

      load(8, 128'hFAAA5612ADC8BC05);
      run_pkt(1'b0, 0, -1, 0);
      run_pkt(1'b1, 0, -1, 0);

      load(1, 128'hFF);
      run_pkt(1'b0, 0, 0, 0);
      load(2, 128'hFFAA);
      run_pkt(1'b0, 0, 2, 0);

      load(10, 128'h09080706050403020100);
      run_pkt(1'b0, 0, 56, 0);

      load(8, 128'h0102030405060708);
      run_pkt(1'b0, 1, 7, 0);

      // Reset pulse while both instances are mid-sort
      load(8, 128'h0807060504030201);
      send_pkt(1'b0, 0);
      val_i = 1'b0; sop_i = 1'b0; eop_i = 1'b0;
      repeat (10) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      for (int d = 0; d < 2; d++) begin
         chk("midsort_rst_busy", d, o_busy[d], 0);
         chk("midsort_rst_outs", d, {o_val[d], o_sop[d], o_eop[d], o_err[d], o_data[d]}, 0);
      end
      @(posedge clk); #1 rst_n = 1'b1;
      load(8, 128'h30A0_1090_3080_2070);
      run_pkt(1'b0, 0, -1, 0);

      for (int t = 0; t < 12; t++) begin
         pkt_n = 1 + ($urandom % 11);
         for (int k = 0; k < pkt_n; k++) pkt_w[k] = DW'($urandom % 6 == 0 ? 8'h80 : $urandom);
         run_pkt(1'($urandom % 2), 2, -1, $urandom % 3);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
